// File: rtl/lab4_g29_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : lab4_g29_scan_mux
//  Purpose  : Registered N-channel multiplexer. In manual mode it presents the
//             channel picked by sel. In auto-scan mode it cycles through the
//             channels enabled in mask, showing each one for DWELL enabled
//             cycles and pulsing wrap when the scan returns to the lowest
//             enabled channel.
//  Ports    : clk    - clock, rising edge
//             rst_n  - synchronous active-low reset
//             en     - block enable (0 freezes all state, drops valid/wrap)
//             mode   - 0 = manual select, 1 = auto-scan
//             sel    - manual channel index
//             mask   - per-channel scan enable (bit i = channel i)
//             din    - flattened inputs, channel i at din[i*WIDTH +: WIDTH]
//             y      - registered selected data
//             ch     - index of the channel currently on y
//             valid  - y/ch hold a legal, selected sample
//             wrap   - one-cycle pulse when the scan wraps around
//             y_par  - even parity of y (only with LAB4_SCAN_MUX_PARITY_EN)
//  Options  : LAB4_SCAN_MUX_PARITY_EN adds the y_par output.
//  Revision : 1.0 - initial release
// ============================================================================
module lab4_g29_scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    // Derived from CHANNELS; not meant to be overridden.
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS-1:0]       mask,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          y,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      wrap
`ifdef LAB4_SCAN_MUX_PARITY_EN
    ,
    output logic                      y_par
`endif
);

    localparam logic [15:0] c_DWELL_LAST = 16'(DWELL - 1);

    typedef enum logic [0:0] {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [SELW-1:0]      r_ptr_q,   w_ptr_d;
    logic [15:0]          r_cnt_q,   w_cnt_d;
    // Set while scanning with an all-zero mask; the next nonzero mask restarts
    // at its lowest channel instead of continuing the old dwell.
    logic                 r_idle_q,  w_idle_d;
    logic [WIDTH-1:0]     r_y_q,     w_y_d;
    logic [SELW-1:0]      r_ch_q,    w_ch_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_wrap_q,  w_wrap_d;

    logic                 w_mask_any;
    logic                 w_above_any;
    logic [SELW-1:0]      w_low;
    logic [SELW-1:0]      w_next;

    // Out-of-range indices (non power-of-two CHANNELS) return zero.
    function automatic logic [WIDTH-1:0] f_pick(
        input logic [SELW-1:0]           idx,
        input logic [CHANNELS*WIDTH-1:0] bus
    );
        f_pick = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == SELW'(i)) f_pick = bus[i*WIDTH +: WIDTH];
        end
    endfunction

    // Lowest enabled channel, and the lowest enabled channel strictly above
    // the pointer. With nothing above, the advance falls back to the lowest
    // enabled channel, which is by definition a wrap-around.
    always_comb begin
        w_mask_any  = |mask;
        w_low       = '0;
        w_next      = '0;
        w_above_any = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_low = SELW'(i);
                if (SELW'(i) > r_ptr_q) begin
                    w_next      = SELW'(i);
                    w_above_any = 1'b1;
                end
            end
        end
        if (!w_above_any) w_next = w_low;
    end

    // Outputs follow mode directly, so a mode change shows on the next edge.
    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        w_idle_d  = r_idle_q;
        w_y_d     = r_y_q;
        w_ch_d    = r_ch_q;
        w_valid_d = 1'b0;
        w_wrap_d  = 1'b0;
        if (en) begin
            if (!mode) begin
                w_state_d = S_MANUAL;
                w_ptr_d   = '0;
                w_cnt_d   = '0;
                w_idle_d  = 1'b0;
                w_y_d     = f_pick(sel, din);
                w_ch_d    = sel;
                w_valid_d = (int'(sel) < CHANNELS);
            end else begin
                w_state_d = S_SCAN;
                if (!w_mask_any) begin
                    // Nothing to scan: hold y/ch, keep the dwell at zero.
                    w_idle_d = 1'b1;
                    w_cnt_d  = '0;
                end else begin
                    if (r_state_q == S_MANUAL || r_idle_q) begin
                        w_ptr_d = w_low;
                        w_cnt_d = '0;
                    end else if (r_cnt_q == c_DWELL_LAST) begin
                        w_ptr_d  = w_next;
                        w_cnt_d  = '0;
                        w_wrap_d = !w_above_any;
                    end else begin
                        w_cnt_d = r_cnt_q + 16'd1;
                    end
                    w_idle_d  = 1'b0;
                    // Live sampling: the channel is re-read every cycle.
                    w_y_d     = f_pick(w_ptr_d, din);
                    w_ch_d    = w_ptr_d;
                    w_valid_d = 1'b1;
                end
            end
        end
    end

`ifdef LAB4_SCAN_MUX_PARITY_EN
    logic r_par_q;
    always_ff @(posedge clk) begin
        if (!rst_n) r_par_q <= 1'b0;
        else        r_par_q <= ^w_y_d;
    end
    assign y_par = r_par_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= S_MANUAL;
            r_ptr_q   <= '0;
            r_cnt_q   <= '0;
            r_idle_q  <= 1'b0;
            r_y_q     <= '0;
            r_ch_q    <= '0;
            r_valid_q <= 1'b0;
            r_wrap_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_cnt_q   <= w_cnt_d;
            r_idle_q  <= w_idle_d;
            r_y_q     <= w_y_d;
            r_ch_q    <= w_ch_d;
            r_valid_q <= w_valid_d;
            r_wrap_q  <= w_wrap_d;
        end
    end

    assign y     = r_y_q;
    assign ch    = r_ch_q;
    assign valid = r_valid_q;
    assign wrap  = r_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_lab4_g29_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab4_g29_scan_mux
//  Purpose  : Self-checking bench for lab4_g29_scan_mux (WIDTH=8, CHANNELS=4,
//             DWELL=2). A reference model predicts every cycle's outputs into
//             a queue; a monitor pops and compares after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lab4_g29_scan_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DWELL    = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic [31:0] din;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        valid, wrap;
`ifdef LAB4_SCAN_MUX_PARITY_EN
    logic        y_par;
`endif

    lab4_g29_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .sel  (sel),
        .mask (mask),
        .din  (din),
        .y    (y),
        .ch   (ch),
        .valid(valid),
        .wrap (wrap)
`ifdef LAB4_SCAN_MUX_PARITY_EN
        ,
        .y_par(y_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic [1:0] ch;
        logic       valid;
        logic       wrap;
        logic       par;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: "left" counts how many more cycles the current channel
    // stays on screen; the next channel is found by stepping around the ring.
    bit         m_scan = 0;
    bit         m_idle = 0;
    int         m_cur  = 0;
    int         m_left = 0;
    logic [7:0] m_y    = '0;
    logic [1:0] m_ch   = '0;

    always @(posedge clk) begin
        exp_t e;
        int   nxt;
        e.valid = 1'b0;
        e.wrap  = 1'b0;
        if (!rst_n) begin
            m_scan = 0; m_idle = 0; m_cur = 0; m_left = 0;
            m_y = '0; m_ch = '0;
        end else if (en) begin
            if (!mode) begin
                m_scan  = 0;
                m_idle  = 0;
                m_ch    = sel;
                e.valid = (int'(sel) < CHANNELS);
                m_y     = e.valid ? din[int'(sel)*8 +: 8] : 8'h00;
            end else begin
                if (mask == 4'b0000) begin
                    m_idle = 1;
                end else begin
                    if (!m_scan || m_idle) begin
                        m_cur = 0;
                        while (!mask[m_cur]) m_cur++;
                        m_left = DWELL - 1;
                    end else if (m_left == 0) begin
                        nxt = m_cur;
                        for (int k = 1; k <= CHANNELS; k++) begin
                            if (mask[(m_cur + k) % CHANNELS]) begin
                                nxt = (m_cur + k) % CHANNELS;
                                break;
                            end
                        end
                        e.wrap = (nxt <= m_cur);
                        m_cur  = nxt;
                        m_left = DWELL - 1;
                    end else begin
                        m_left--;
                    end
                    m_idle  = 0;
                    m_ch    = 2'(m_cur);
                    m_y     = din[m_cur*8 +: 8];
                    e.valid = 1'b1;
                end
                m_scan = 1;
            end
        end
        e.y   = m_y;
        e.ch  = m_ch;
        e.par = ^m_y;
        q.push_back(e);
    end

    // Monitor: compares the DUT against the oldest prediction after each edge.
    always @(posedge clk) begin
        exp_t e;
        bit   bad;
        #1;
        cyc++;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL cycle %0d: scoreboard empty", cyc);
        end else begin
            e   = q.pop_front();
            bad = (y !== e.y) || (ch !== e.ch) || (valid !== e.valid) || (wrap !== e.wrap);
`ifdef LAB4_SCAN_MUX_PARITY_EN
            bad = bad || (y_par !== e.par);
`endif
            if (bad) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got y=%h ch=%0d valid=%b wrap=%b, expected y=%h ch=%0d valid=%b wrap=%b",
                         cyc, y, ch, valid, wrap, e.y, e.ch, e.valid, e.wrap);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0;
        mask  = 4'b1111; din = 32'hA5C3_5A3C;
        tick(2);

        // Release reset: nothing changes until the next edge.
        rst_n = 1'b1; mode = 1'b0; sel = 2'd0;
        #1;
        n_cmp++;
        if (y !== 8'h00 || ch !== 2'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL post_release: got y=%h ch=%0d valid=%b wrap=%b, expected all zero",
                     y, ch, valid, wrap);
        end

        // Manual select sweep.
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick(1);
        end

        // Scan over channels 0,1,3.
        mask = 4'b1011; mode = 1'b1;
        tick(8);
        // Single channel wraps onto itself.
        mask = 4'b0100;
        tick(6);
        // Empty mask, then resume.
        mask = 4'b0000;
        tick(3);
        mask = 4'b0001;
        tick(2);
        // Enable hold mid-dwell.
        mask = 4'b1011;
        tick(3);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(4);
        // Back to manual.
        mode = 1'b0; sel = 2'd2;
        tick(2);
        // Reset during scan.
        mode = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1; mode = 1'b0; sel = 2'd0;
        // Parity-relevant values.
        din[7:0] = 8'h07;
        tick(1);
        din[7:0] = 8'h03;
        tick(1);

        // Randomised phase.
        for (int i = 0; i < 400; i++) begin
            din   = $urandom;
            en    = ($urandom_range(0, 9) != 0);
            sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0)  mask = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 63) != 0);
            tick(1);
        end
        rst_n = 1'b1; en = 1'b1;
        tick(2);

        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
